// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Optional stall counter is enabled with PIPE_PERF_CNT_EN.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } mem_st_t;

    typedef struct packed {
        logic pc_w;
        logic if_id_w;
        logic id_ex_w;
        logic ex_mem_w;
        logic if_id_f;
        logic id_ex_f;
        logic mem_wb_f;
    } ctl_t;

    // Hold every register and flush every stage: the reset bubble.
    localparam ctl_t CTL_BUBBLE = 7'b0000_111;
    localparam ctl_t CTL_RUN    = 7'b1111_000;
    localparam ctl_t CTL_FREEZE = 7'b0000_001;
    localparam ctl_t CTL_BRANCH = 7'b1111_110;
    localparam ctl_t CTL_HOLD   = 7'b0011_010;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle.
// stall_cycles exists only with PIPE_PERF_CNT_EN.
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_W-1:0] ID_rs;
    logic [REG_W-1:0] ID_rt;
    logic             ID_UseRs;
    logic             ID_UseRt;
    logic             EX_MemRead;
    logic [REG_W-1:0] EX_WriteReg;
    logic             EX_BranchTaken;
    logic             MEM_MemRead;
    logic             MEM_MemWrite;
    logic             dmem_ack;
    logic             dmem_req;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             ID_EX_Write;
    logic             EX_MEM_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             MEM_WB_Flush;
    logic             mem_err;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0]      stall_cycles;

    modport master (
        output ID_rs, ID_rt, ID_UseRs, ID_UseRt, EX_MemRead,
               EX_WriteReg, EX_BranchTaken, MEM_MemRead,
               MEM_MemWrite, dmem_ack,
        input  dmem_req, PC_Write, IF_ID_Write, ID_EX_Write,
               EX_MEM_Write, IF_ID_Flush, ID_EX_Flush,
               MEM_WB_Flush, mem_err, stall_cycles
    );
    modport slave (
        input  ID_rs, ID_rt, ID_UseRs, ID_UseRt, EX_MemRead,
               EX_WriteReg, EX_BranchTaken, MEM_MemRead,
               MEM_MemWrite, dmem_ack,
        output dmem_req, PC_Write, IF_ID_Write, ID_EX_Write,
               EX_MEM_Write, IF_ID_Flush, ID_EX_Flush,
               MEM_WB_Flush, mem_err, stall_cycles
    );
`else
    modport master (
        output ID_rs, ID_rt, ID_UseRs, ID_UseRt, EX_MemRead,
               EX_WriteReg, EX_BranchTaken, MEM_MemRead,
               MEM_MemWrite, dmem_ack,
        input  dmem_req, PC_Write, IF_ID_Write, ID_EX_Write,
               EX_MEM_Write, IF_ID_Flush, ID_EX_Flush,
               MEM_WB_Flush, mem_err
    );
    modport slave (
        input  ID_rs, ID_rt, ID_UseRs, ID_UseRt, EX_MemRead,
               EX_WriteReg, EX_BranchTaken, MEM_MemRead,
               MEM_MemWrite, dmem_ack,
        output dmem_req, PC_Write, IF_ID_Write, ID_EX_Write,
               EX_MEM_Write, IF_ID_Flush, ID_EX_Flush,
               MEM_WB_Flush, mem_err
    );
`endif

endinterface

// File: rtl/pipe_hazard_ctrl_mem_wait_fsm.sv
// Data-memory request/ack FSM with wait timeout and sticky error.
module mem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_acc,
    input  logic i_ack,
    output logic o_req,
    output logic o_stall,
    output logic o_err
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    mem_st_t       r_state;
    logic [CW-1:0] r_cnt;
    logic          r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_acc && !i_ack) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (i_ack) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_ERR:  r_state <= ST_ERR;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req   = ((r_state == ST_IDLE) & i_acc) | (r_state == ST_BUSY);
    assign o_stall = (o_req & ~i_ack) | (r_state == ST_ERR);
    assign o_err   = r_err;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: memory wait, load-use, taken branch.
// Define PIPE_PERF_CNT_EN to add the saturating stall_cycles counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);

    logic w_acc;
    logic w_req;
    logic w_stall;
    logic w_err;
    logic w_lu;
    logic w_rs_hit;
    logic w_rt_hit;
    ctl_t w_ctl;

    assign w_acc = bus.MEM_MemRead | bus.MEM_MemWrite;

    mem_wait_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_acc   (w_acc),
        .i_ack   (bus.dmem_ack),
        .o_req   (w_req),
        .o_stall (w_stall),
        .o_err   (w_err)
    );

    assign w_rs_hit = bus.ID_UseRs & (bus.ID_rs == bus.EX_WriteReg);
    assign w_rt_hit = bus.ID_UseRt & (bus.ID_rt == bus.EX_WriteReg);
    assign w_lu     = bus.EX_MemRead & (bus.EX_WriteReg != '0)
                    & (w_rs_hit | w_rt_hit);

    // A taken branch squashes the dependent instruction, so it beats lu.
    always_comb begin
        w_ctl = CTL_RUN;
        if (!rst)
            w_ctl = CTL_BUBBLE;
        else if (w_stall)
            w_ctl = CTL_FREEZE;
        else if (bus.EX_BranchTaken)
            w_ctl = CTL_BRANCH;
        else if (w_lu)
            w_ctl = CTL_HOLD;
    end

    assign bus.dmem_req     = rst & w_req;
    assign bus.mem_err      = w_err;
    assign bus.PC_Write     = w_ctl.pc_w;
    assign bus.IF_ID_Write  = w_ctl.if_id_w;
    assign bus.ID_EX_Write  = w_ctl.id_ex_w;
    assign bus.EX_MEM_Write = w_ctl.ex_mem_w;
    assign bus.IF_ID_Flush  = w_ctl.if_id_f;
    assign bus.ID_EX_Flush  = w_ctl.id_ex_f;
    assign bus.MEM_WB_Flush = w_ctl.mem_wb_f;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic        w_cnt_inc;

    assign w_cnt_inc = w_stall | (w_lu & ~bus.EX_BranchTaken);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if (w_cnt_inc && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign bus.stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (MEM_TIMEOUT = 4).
// Checks stall_cycles too when PIPE_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

    localparam logic [6:0] E_RST = 7'b0000111;
    localparam logic [6:0] E_RUN = 7'b1111000;
    localparam logic [6:0] E_STL = 7'b0000001;
    localparam logic [6:0] E_BR  = 7'b1111110;
    localparam logic [6:0] E_LU  = 7'b0011010;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   exp_stall;

    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ctl_now();
        return {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Write,
                bus.EX_MEM_Write, bus.IF_ID_Flush, bus.ID_EX_Flush,
                bus.MEM_WB_Flush};
    endfunction

    task automatic idle_in();
        bus.ID_rs          = '0;
        bus.ID_rt          = '0;
        bus.ID_UseRs       = 1'b0;
        bus.ID_UseRt       = 1'b0;
        bus.EX_MemRead     = 1'b0;
        bus.EX_WriteReg    = '0;
        bus.EX_BranchTaken = 1'b0;
        bus.MEM_MemRead    = 1'b0;
        bus.MEM_MemWrite   = 1'b0;
        bus.dmem_ack       = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] wr, input logic [4:0] rs,
                            input logic [4:0] rt, input logic urs,
                            input logic urt);
        bus.EX_MemRead  = 1'b1;
        bus.EX_WriteReg = wr;
        bus.ID_rs       = rs;
        bus.ID_rt       = rt;
        bus.ID_UseRs    = urs;
        bus.ID_UseRt    = urt;
    endtask

    // Called just after a negedge with inputs set; ends at the next negedge.
    task automatic cyc(input string tag, input logic [6:0] e_ctl,
                       input logic e_req, input logic e_err);
        #1;
        chk({tag, ".ctl"}, 32'(ctl_now()), 32'(e_ctl));
        chk({tag, ".req"}, 32'(bus.dmem_req), 32'(e_req));
        chk({tag, ".err"}, 32'(bus.mem_err), 32'(e_err));
`ifdef PIPE_PERF_CNT_EN
        chk({tag, ".perf"}, bus.stall_cycles, exp_stall);
`endif
        if (!rst)
            exp_stall = 0;
        else if (e_ctl == E_STL || e_ctl == E_LU)
            exp_stall++;
        @(negedge clk);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        exp_stall = 0;
        rst       = 1'b0;
        idle_in();
        bus.MEM_MemRead = 1'b1;
        @(negedge clk);
        cyc("reset", E_RST, 1'b0, 1'b0);
        rst = 1'b1;
        idle_in();
        cyc("idle", E_RUN, 1'b0, 1'b0);

        load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        cyc("lu_rs", E_LU, 1'b0, 1'b0);
        idle_in();
        cyc("lu_after", E_RUN, 1'b0, 1'b0);
        load_use(5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        cyc("lu_unused", E_RUN, 1'b0, 1'b0);
        load_use(5'd9, 5'd1, 5'd9, 1'b1, 1'b1);
        cyc("lu_rt", E_LU, 1'b0, 1'b0);
        load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        cyc("lu_r0", E_RUN, 1'b0, 1'b0);
        load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        bus.EX_BranchTaken = 1'b1;
        cyc("br_lu", E_BR, 1'b0, 1'b0);
        idle_in();

        bus.MEM_MemRead = 1'b1;
        bus.dmem_ack    = 1'b1;
        cyc("zw_acc", E_RUN, 1'b1, 1'b0);
        idle_in();
        cyc("zw_idle", E_RUN, 1'b0, 1'b0);
        bus.dmem_ack = 1'b1;
        cyc("stray_ack", E_RUN, 1'b0, 1'b0);
        bus.dmem_ack = 1'b0;
        cyc("stray_ack2", E_RUN, 1'b0, 1'b0);

        bus.MEM_MemWrite = 1'b1;
        load_use(5'd7, 5'd7, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("w3_wait%0d", i), E_STL, 1'b1, 1'b0);
        bus.dmem_ack = 1'b1;
        cyc("w3_ack", E_LU, 1'b1, 1'b0);
        idle_in();
        cyc("w3_done", E_RUN, 1'b0, 1'b0);

        bus.MEM_MemRead = 1'b1;
        for (int i = 0; i < 5; i++)
            cyc($sformatf("to_wait%0d", i), E_STL, 1'b1, 1'b0);
        cyc("to_err", E_STL, 1'b0, 1'b1);
        idle_in();
        bus.dmem_ack       = 1'b1;
        bus.EX_BranchTaken = 1'b1;
        cyc("err_frozen", E_STL, 1'b0, 1'b1);
        idle_in();

        #2 rst = 1'b0;
        exp_stall = 0;
        #1;
        chk("err_rst.ctl", 32'(ctl_now()), 32'(E_RST));
        chk("err_rst.err", 32'(bus.mem_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc("err_clr", E_RUN, 1'b0, 1'b0);

        bus.MEM_MemRead = 1'b1;
        cyc("rb_req", E_STL, 1'b1, 1'b0);
        cyc("rb_busy0", E_STL, 1'b1, 1'b0);
        cyc("rb_busy1", E_STL, 1'b1, 1'b0);
        #2 rst = 1'b0;
        exp_stall = 0;
        #1;
        chk("rb_async.ctl", 32'(ctl_now()), 32'(E_RST));
        chk("rb_async.req", 32'(bus.dmem_req), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle_in();
        cyc("rb_idle", E_RUN, 1'b0, 1'b0);
        bus.MEM_MemRead = 1'b1;
        for (int i = 0; i < 5; i++)
            cyc($sformatf("rb_cnt%0d", i), E_STL, 1'b1, 1'b0);
        cyc("rb_to", E_STL, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. Each cycle it decides whether the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers advance, hold or take a bubble. It runs the data-memory request/acknowledge handshake for the MEM stage and detects load-use hazards and taken branches. It sits beside the datapath and drives the write-enable and flush inputs of every pipeline register.

## Interface
- MEM_TIMEOUT, 255: max cycles a memory access may wait for `dmem_ack` before error; ≥1.
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
- ID_UseRs, ID_UseRt  in  1 each  ID instruction actually reads rs / rt.
- EX_MemRead  in  1  EX instruction is a load.
- EX_WriteReg  in  5  destination register of the EX instruction.
- EX_BranchTaken  in  1  branch/jump resolved taken in EX.
- MEM_MemRead, MEM_MemWrite  in  1 each  MEM instruction accesses data memory.
- dmem_ack  in  1  data memory completes the current access this cycle.
- dmem_req  out  1  access request to data memory.
- PC_Write, IF_ID_Write  out  1 each  advance enables.
- ID_EX_Write, EX_MEM_Write  out  1 each  advance enables.
- IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush  out  1 each  load a bubble (all-zero controls) at next edge.
- mem_err  out  1  sticky memory-timeout error.
- stall_cycles  out  32  stall-cycle counter; present only with `PIPE_PERF_CNT_EN`.

## Operation
- Memory FSM states: IDLE, BUSY, ERR.
- Define `acc = MEM_MemRead | MEM_MemWrite`.
- `dmem_req = (IDLE & acc) | BUSY`.
- IDLE, `acc & dmem_ack`: zero-wait access. Stay IDLE; the pipeline advances.
- IDLE, `acc & !dmem_ack`: go to BUSY and clear the wait counter.
- BUSY, `dmem_ack`: go to IDLE; the pipeline advances this edge.
- BUSY, no ack, counter = MEM_TIMEOUT−1: go to ERR and set `mem_err`.
- BUSY otherwise: increment the counter.
- ERR: absorbing until reset. `dmem_req=0`; the pipeline is frozen permanently.
- `mem_stall = (dmem_req & !dmem_ack) | ERR`.
- Load-use condition `lu = EX_MemRead & EX_WriteReg≠0 & ((ID_UseRs & ID_rs==EX_WriteReg) | (ID_UseRt & ID_rt==EX_WriteReg))`.
- Priority 1, mem_stall: all `*_Write=0`, `MEM_WB_Flush=1`, other flushes 0.
- Priority 2, EX_BranchTaken: all writes 1, `IF_ID_Flush=1`, `ID_EX_Flush=1`. This overrides `lu`, because the dependent instruction is squashed.
- Priority 3, lu: `PC_Write=0`, `IF_ID_Write=0`, `ID_EX_Flush=1`, other writes 1.
- Otherwise: all writes 1, all flushes 0.
- Register 0 never causes a hazard.

## Timing
- Control outputs are combinational from FSM state and current inputs. There are no registered outputs except `mem_err` and `stall_cycles`.
- Load-use costs exactly 1 bubble.
- A taken branch costs 2 squashed slots.
- A memory access with N wait cycles freezes the pipeline for N cycles.
- While `rst` is low:
  - FSM = IDLE, counter = 0, `mem_err=0`, `stall_cycles=0`.
  - `dmem_req=0`, all `*_Write=0`, all flushes 1.
- Reset asserted mid-access abandons the access immediately; no ack is awaited after release.
- `dmem_ack` in IDLE with `acc=0` is ignored.
- The load-use check is blocked during mem_stall; it re-evaluates when the stall releases.

## Configuration
- `PIPE_PERF_CNT_EN` defined: `stall_cycles` increments on every cycle with mem_stall or lu (branch excluded). It saturates at 0xFFFFFFFF.
- `PIPE_PERF_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - memory FSM state encoding (IDLE=2'd0, BUSY=2'd1, ERR=2'd2);
  - register-index width (5);
  - the bubble constant.
- Sub-module `mem_wait_fsm` owns the FSM, wait counter (width `$clog2(MEM_TIMEOUT+1)`) and `mem_err`. It outputs `dmem_req` and `mem_stall`.
- The top level holds the hazard/priority logic and the optional perf counter.

## Test plan
- Load-use: load writes r5 in EX, ID reads rs=5 → one cycle of `PC_Write=0`, `IF_ID_Write=0`, `ID_EX_Flush=1`, then normal. The same case with `EX_WriteReg=0` → no stall.
- Branch + load-use in the same cycle → `IF_ID_Flush=ID_EX_Flush=1`, `PC_Write=1`; no hold.
- Zero-wait access: `MEM_MemRead=1`, ack in the same cycle → `dmem_req=1`, no stall, FSM stays IDLE.
- 3-wait access: ack on the 4th cycle → 3 cycles of all writes 0 with `MEM_WB_Flush=1`; advance on the ack edge; `stall_cycles` +3.
- Timeout with MEM_TIMEOUT=4 and no ack → `mem_err=1` after 4 BUSY cycles, pipeline frozen, `dmem_req=0`. Only reset clears it.
- Reset asserted in BUSY → outputs take reset values asynchronously. After release: FSM IDLE, `mem_err=0`, counter 0.
